// File: rtl/multi_bit_sync_edge.sv
// -----------------------------------------------------------------------------
// multi_bit_sync_edge
//
// Receive-side synchroniser for CH independent asynchronous single-bit event
// lines, running entirely in the destination clock domain. Per channel:
//   SYNC_STAGES-deep synchroniser chain -> optional glitch filter ->
//   registered edge detector -> saturating event counter + sticky flag.
//
// Optional feature macro: SYNC_FILTER_EN
//   defined   : a per-channel filter follows the last chain stage. sync_out
//               takes a new level only after FILT_LEN consecutive samples
//               that differ from it; any matching sample restarts the count.
//   undefined : no filter logic, sync_out is the last chain stage.
//
// Ports:
//   clk         in   destination clock
//   sys_rst     in   synchronous active-high reset, zeroes every flop
//   async_in    in   [CH]        asynchronous event lines
//   sync_out    out  [CH]        synchronised (optionally filtered) level
//   edge_pulse  out  [CH]        one-cycle registered pulse per detected edge
//   evt_cnt     out  [CH*CNT_W]  saturating event counts, ch i at [i*CNT_W +: CNT_W]
//   cnt_clr     in   [CH]        per-channel counter clear
//   sticky      out  [CH]        per-channel event-seen flag
//   sticky_clr  in   1           clears all sticky flags
// -----------------------------------------------------------------------------
module multi_bit_sync_edge #(
   parameter int unsigned CH          = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [1:0]  EDGE_MODE   = 2'd0,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic                  clk,
   input  logic                  sys_rst,
   input  logic [CH-1:0]         async_in,
   output logic [CH-1:0]         sync_out,
   output logic [CH-1:0]         edge_pulse,
   output logic [CH*CNT_W-1:0]   evt_cnt,
   input  logic [CH-1:0]         cnt_clr,
   output logic [CH-1:0]         sticky,
   input  logic                  sticky_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Edge condition selected by EDGE_MODE; code 3 behaves like "both".
   function automatic logic edge_hit(input logic cur, input logic prv, input logic [1:0] mode);
      logic hit;
      case (mode)
         2'd0:    hit = cur & ~prv;
         2'd1:    hit = ~cur & prv;
         default: hit = cur ^ prv;
      endcase
      return hit;
   endfunction

   logic [CH-1:0][SYNC_STAGES-1:0] chain_d, chain_q;
   logic [CH-1:0]                  sync_cur;
   logic [CH-1:0]                  evt;
   logic [CH-1:0]                  prev_d, prev_q;
   logic [CH-1:0]                  pulse_d, pulse_q;
   logic [CH-1:0][CNT_W-1:0]       cnt_d, cnt_q;
   logic [CH-1:0]                  sticky_d, sticky_q;

   // Synchroniser chain shift: only bit 0 ever samples the asynchronous input.
   always_comb begin
      chain_d = chain_q;
      for (int i = 0; i < CH; i++) begin
         chain_d[i] = {chain_q[i][SYNC_STAGES-2:0], async_in[i]};
      end
   end

`ifdef SYNC_FILTER_EN
   localparam int unsigned      FC_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FC_W-1:0]  FILT_LAST = FC_W'(FILT_LEN - 1);
   localparam logic [FC_W-1:0]  FC_ZERO   = {FC_W{1'b0}};
   localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(1);

   logic [CH-1:0]            filt_d, filt_q;
   logic [CH-1:0][FC_W-1:0]  fcnt_d, fcnt_q;

   // Glitch filter: flip on the FILT_LEN-th consecutive differing sample.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      for (int i = 0; i < CH; i++) begin
         if (chain_q[i][SYNC_STAGES-1] != filt_q[i]) begin
            if (fcnt_q[i] == FILT_LAST) begin
               filt_d[i] = chain_q[i][SYNC_STAGES-1];
               fcnt_d[i] = FC_ZERO;
            end else begin
               fcnt_d[i] = fcnt_q[i] + FC_ONE;
            end
         end else begin
            fcnt_d[i] = FC_ZERO;
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         filt_q <= {CH{1'b0}};
         fcnt_q <= {CH{FC_ZERO}};
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   // Filtered level is the synchronised output.
   always_comb begin
      sync_cur = filt_q;
   end
`else
   // Last chain stage is the synchronised output.
   always_comb begin
      sync_cur = {CH{1'b0}};
      for (int i = 0; i < CH; i++) begin
         sync_cur[i] = chain_q[i][SYNC_STAGES-1];
      end
   end
`endif

   // Edge detection, saturating counter and sticky flag next-state.
   always_comb begin
      evt      = {CH{1'b0}};
      prev_d   = sync_cur;
      pulse_d  = {CH{1'b0}};
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      for (int i = 0; i < CH; i++) begin
         evt[i]     = edge_hit(sync_cur[i], prev_q[i], EDGE_MODE);
         pulse_d[i] = evt[i];
         if (evt[i]) begin
            // A clear coinciding with an event keeps that event as count 1.
            if (cnt_clr[i]) begin
               cnt_d[i] = CNT_ONE;
            end else if (cnt_q[i] == CNT_MAX) begin
               cnt_d[i] = cnt_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end else if (cnt_clr[i]) begin
            cnt_d[i] = {CNT_W{1'b0}};
         end else begin
            cnt_d[i] = cnt_q[i];
         end
         // Event wins over a simultaneous clear.
         sticky_d[i] = evt[i] | (sticky_q[i] & ~sticky_clr);
      end
   end

   // Chain and event-path registers.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         chain_q  <= {CH{{SYNC_STAGES{1'b0}}}};
         prev_q   <= {CH{1'b0}};
         pulse_q  <= {CH{1'b0}};
         cnt_q    <= {CH{{CNT_W{1'b0}}}};
         sticky_q <= {CH{1'b0}};
      end else begin
         chain_q  <= chain_d;
         prev_q   <= prev_d;
         pulse_q  <= pulse_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
      end
   end

   assign sync_out   = sync_cur;
   assign edge_pulse = pulse_q;
   assign evt_cnt    = cnt_q;
   assign sticky     = sticky_q;

endmodule

// File: tb/tb_multi_bit_sync_edge.sv
// -----------------------------------------------------------------------------
// Bench for multi_bit_sync_edge. Two instances share the same stimulus:
//   dut_a : defaults (rising edges, 8-bit counters)
//   dut_b : both-edge mode, 2-bit counters (fast saturation)
// A behavioural model predicts every output from a sample history of the
// inputs; outputs are compared on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multi_bit_sync_edge;

   localparam int CH   = 4;
   localparam int SS   = 2;
   localparam int FL   = 3;
   localparam int CW_A = 8;
   localparam int CW_B = 2;
`ifdef SYNC_FILTER_EN
   localparam int EVT_LAT = SS + FL;
`else
   localparam int EVT_LAT = SS;
`endif
   localparam int HL = SS - 1 + FL;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 sys_rst;
   logic [CH-1:0]        async_in;
   logic [CH-1:0]        cnt_clr;
   logic                 sticky_clr;
   logic [CH-1:0]        a_sync, a_edge, a_sticky, b_sync, b_edge, b_sticky;
   logic [CH*CW_A-1:0]   a_cnt;
   logic [CH*CW_B-1:0]   b_cnt;

   multi_bit_sync_edge #(.CH(CH), .SYNC_STAGES(SS), .EDGE_MODE(2'd0), .CNT_W(CW_A), .FILT_LEN(FL)) dut_a (
      .clk(clk), .sys_rst(sys_rst), .async_in(async_in), .sync_out(a_sync),
      .edge_pulse(a_edge), .evt_cnt(a_cnt), .cnt_clr(cnt_clr), .sticky(a_sticky),
      .sticky_clr(sticky_clr));

   multi_bit_sync_edge #(.CH(CH), .SYNC_STAGES(SS), .EDGE_MODE(2'd2), .CNT_W(CW_B), .FILT_LEN(FL)) dut_b (
      .clk(clk), .sys_rst(sys_rst), .async_in(async_in), .sync_out(b_sync),
      .edge_pulse(b_edge), .evt_cnt(b_cnt), .cnt_clr(cnt_clr), .sticky(b_sticky),
      .sticky_clr(sticky_clr));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [CH-1:0] hist [$];        // hist[0] = most recent sampled input
   bit  m_sync [CH];
   bit  m_prev [CH];
   bit  m_pulse [2][CH];
   bit  m_sticky [2][CH];
   int  m_cnt [2][CH];
   int  cmax [2] = '{255, 3};
   int  mode [2] = '{0, 2};

   function automatic bit hit(input int md, input bit cur, input bit prv);
      if (md == 0) return cur && !prv;
      if (md == 1) return !cur && prv;
      return cur != prv;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int j = 0; j < HL; j++) hist.push_back('0);
      for (int c = 0; c < CH; c++) begin
         m_sync[c] = 1'b0;
         m_prev[c] = 1'b0;
         for (int u = 0; u < 2; u++) begin
            m_pulse[u][c]  = 1'b0;
            m_sticky[u][c] = 1'b0;
            m_cnt[u][c]    = 0;
         end
      end
   endtask

   // Predict the state after the coming rising edge, given the driven inputs.
   task automatic model_edge();
      bit nsync;
      bit all_diff;
      bit e;
      if (sys_rst) begin
         model_reset();
         return;
      end
      for (int c = 0; c < CH; c++) begin
         for (int u = 0; u < 2; u++) begin
            e = hit(mode[u], m_sync[c], m_prev[c]);
            m_pulse[u][c] = e;
            if (e) m_cnt[u][c] = cnt_clr[c] ? 1 : ((m_cnt[u][c] < cmax[u]) ? m_cnt[u][c] + 1 : m_cnt[u][c]);
            else if (cnt_clr[c]) m_cnt[u][c] = 0;
            m_sticky[u][c] = e || (m_sticky[u][c] && !sticky_clr);
         end
`ifdef SYNC_FILTER_EN
         // Flip once the last FL samples seen by the filter all disagree.
         all_diff = 1'b1;
         for (int j = 0; j < FL; j++) if (hist[SS-1+j][c] == m_sync[c]) all_diff = 1'b0;
         nsync = all_diff ? !m_sync[c] : m_sync[c];
`else
         // Output is the input sampled SS-1 edges before this one.
         nsync = hist[SS-2][c];
`endif
         m_prev[c] = m_sync[c];
         m_sync[c] = nsync;
      end
      hist.push_front(async_in);
      void'(hist.pop_back());
   endtask

   task automatic compare_all();
      logic [63:0] es, ep0, ep1, ec0, ec1, et0, et1;
      es = '0; ep0 = '0; ep1 = '0; ec0 = '0; ec1 = '0; et0 = '0; et1 = '0;
      for (int c = 0; c < CH; c++) begin
         es[c]  = m_sync[c];
         ep0[c] = m_pulse[0][c];
         ep1[c] = m_pulse[1][c];
         et0[c] = m_sticky[0][c];
         et1[c] = m_sticky[1][c];
         ec0[c*CW_A +: CW_A] = CW_A'(m_cnt[0][c]);
         ec1[c*CW_B +: CW_B] = CW_B'(m_cnt[1][c]);
      end
      check("a_sync",   64'(a_sync),   es);
      check("a_edge",   64'(a_edge),   ep0);
      check("a_cnt",    64'(a_cnt),    ec0);
      check("a_sticky", 64'(a_sticky), et0);
      check("b_sync",   64'(b_sync),   es);
      check("b_edge",   64'(b_edge),   ep1);
      check("b_cnt",    64'(b_cnt),    ec1);
      check("b_sticky", 64'(b_sticky), et1);
   endtask

   // One cycle: compare at the falling edge, then drive the next inputs.
   task automatic step(input logic [CH-1:0] ain, input logic [CH-1:0] clr,
                       input logic sclr, input logic rst);
      @(negedge clk);
      compare_all();
      async_in   = ain;
      cnt_clr    = clr;
      sticky_clr = sclr;
      sys_rst    = rst;
      model_edge();
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {a_sync, a_edge, a_sticky, b_sync, b_edge, b_sticky, a_cnt, b_cnt}, 64'd0);
   endtask

   logic [CH-1:0] lvl;
   int            hold [CH];

   initial begin
      sys_rst = 1'b1; async_in = '0; cnt_clr = '0; sticky_clr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      step(4'b0000, 4'b0000, 1'b0, 1'b1);

      // Directed: ch0 high 5 cycles then low.
      for (int k = 0; k < 5; k++)  step(4'b0001, 4'b0000, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) step(4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      check("dir_cnt0", 64'(a_cnt[7:0]), 64'd1);
      check("dir_sticky", 64'(a_sticky), 64'b0001);

      // Counter clear and sticky clear coinciding with a ch1 rising event.
      for (int k = 0; k <= EVT_LAT; k++)
         step(4'b0010, (k == EVT_LAT) ? 4'b0010 : 4'b0000, k == EVT_LAT, 1'b0);
      step(4'b0010, 4'b0000, 1'b0, 1'b0);
      check("clr_evt_cnt1", 64'(a_cnt[15:8]), 64'd1);
      check("sclr_evt_sticky1", 64'(a_sticky[1]), 64'd1);
      step(4'b0010, 4'b0000, 1'b1, 1'b0);
      step(4'b0010, 4'b0000, 1'b0, 1'b0);
      check("sclr_alone_sticky1", 64'(a_sticky[1]), 64'd0);
      for (int k = 0; k < 8; k++) step(4'b0000, 4'b0000, 1'b0, 1'b0);

      // Reset one cycle after ch3 rises; held for 4 cycles.
      step(4'b1000, 4'b0000, 1'b0, 1'b0);
      step(4'b1000, 4'b0000, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step(4'b1000, 4'b0000, 1'b0, (k < 3));
         check_all_zero("rst_mid");
      end
      for (int k = 0; k < 12; k++) step(4'b1000, 4'b0000, 1'b0, 1'b0);

      // Randomized levels, clears and occasional resets.
      lvl = '0;
      for (int c = 0; c < CH; c++) hold[c] = 1;
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (hold[c] == 0) begin
               lvl[c]  = ~lvl[c];
               hold[c] = $urandom_range(1, 7);
            end
            hold[c]--;
         end
         step(lvl, 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
      end

      // Saturation: steady toggling on ch0 with no clears.
      for (int n = 0; n < 2800; n++)
         step(((n / 5) % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      check("sat_cnt0_a", 64'(a_cnt[7:0]), 64'd255);
      check("sat_cnt0_b", 64'(b_cnt[1:0]), 64'd3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
